// File: rtl/data_ctrl_and_dm.sv
// Four-port shared data memory: global write strobe, per-core registered reads.
// Optional macro DM_RESET_CLEAR_EN: asynchronous reset also clears the memory array.
module data_ctrl_and_dm #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEMWRITE,
  input  logic [3:0]  MR,
  input  logic [15:0] MADDR1,
  input  logic [15:0] MADDR2,
  input  logic [15:0] MADDR3,
  input  logic [15:0] MADDR4,
  input  logic [63:0] DATAIN,
  output logic [15:0] DOUT1,
  output logic [15:0] DOUT2,
  output logic [15:0] DOUT3,
  output logic [15:0] DOUT4
);

  logic [15:0]   mem_q  [DEPTH];
  logic [15:0]   dout_q [4];
  logic [AW-1:0] idx    [4];
  logic [15:0]   lane   [4];
  logic [3:0]    wr_en;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^{MADDR1[15:AW], MADDR2[15:AW], MADDR3[15:AW], MADDR4[15:AW]};

  // A lane is suppressed when any higher-numbered core targets the same word,
  // so at most one port writes each location per cycle.
  always_comb begin
    idx[0] = MADDR1[AW-1:0];
    idx[1] = MADDR2[AW-1:0];
    idx[2] = MADDR3[AW-1:0];
    idx[3] = MADDR4[AW-1:0];
    for (int n = 0; n < 4; n++) begin
      lane[n] = DATAIN[16*n +: 16];
    end
    for (int n = 0; n < 4; n++) begin
      wr_en[n] = MEMWRITE;
      for (int m = n + 1; m < 4; m++) begin
        if (idx[m] == idx[n]) begin
          wr_en[n] = 1'b0;
        end
      end
    end
  end

`ifdef DM_RESET_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (wr_en[n]) begin
          mem_q[idx[n]] <= lane[n];
        end
      end
    end
  end
`else
  // Array is not reset; writes are still blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int n = 0; n < 4; n++) begin
        if (wr_en[n]) begin
          mem_q[idx[n]] <= lane[n];
        end
      end
    end
  end
`endif

  // Reads sample the pre-write array contents, giving read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        dout_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (MR[n]) begin
          dout_q[n] <= mem_q[idx[n]];
        end
      end
    end
  end

  assign DOUT1 = dout_q[0];
  assign DOUT2 = dout_q[1];
  assign DOUT3 = dout_q[2];
  assign DOUT4 = dout_q[3];

endmodule

// File: tb/tb_data_ctrl_and_dm.sv
// Randomized and directed checks of data_ctrl_and_dm against a behavioural memory model.
module tb_data_ctrl_and_dm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mw = 1'b0;
  logic [3:0]  mr = 4'h0;
  logic [15:0] a [4];
  logic [63:0] din = '0;
  logic [15:0] dout [4];

  logic [15:0] ref_mem  [256];
  logic [15:0] ref_dout [4];
  int total = 0;
  int bad   = 0;

  data_ctrl_and_dm #(.DEPTH(256), .AW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .MEMWRITE (mw),
    .MR       (mr),
    .MADDR1   (a[0]),
    .MADDR2   (a[1]),
    .MADDR3   (a[2]),
    .MADDR4   (a[3]),
    .DATAIN   (din),
    .DOUT1    (dout[0]),
    .DOUT2    (dout[1]),
    .DOUT3    (dout[2]),
    .DOUT4    (dout[3])
  );

  always #5 clk = ~clk;

  // Model one clock edge: reads see the old memory, then cores 1..4 write in order
  // so the highest-numbered core is last and wins a collision.
  task automatic step();
    if (rst_n) begin
      for (int n = 0; n < 4; n++)
        if (mr[n]) ref_dout[n] = ref_mem[a[n] % 256];
      if (mw)
        for (int n = 0; n < 4; n++) ref_mem[a[n] % 256] = din[16*n +: 16];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 4; n++) begin
      a[n] = '0;
      ref_dout[n] = '0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      total++;
      if (dout[n] !== 16'h0000) begin
        bad++;
        $display("FAIL reset_dout%0d got=%h exp=0000", n + 1, dout[n]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    mw = 1'b1;
    mr = 4'h0;
    for (int i = 0; i < 64; i++) begin
      for (int n = 0; n < 4; n++) a[n] = 16'(4 * i + n);
      din = {$urandom, $urandom};
      step();
    end
    mw = 1'b0;
  endtask

  task automatic test_parallel();
    logic [15:0] exp [4];
    exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    mw = 1'b1;
    din = 64'h4444_3333_2222_1111;
    for (int n = 0; n < 4; n++) a[n] = 16'h0010 + 16'(n);
    step();
    mw = 1'b0;
    mr = 4'hF;
    step();
    for (int n = 0; n < 4; n++) begin
      total++;
      if (dout[n] !== exp[n]) begin
        bad++;
        $display("FAIL parallel_dout%0d got=%h exp=%h", n + 1, dout[n], exp[n]);
      end
    end
    mr = 4'h0;
  endtask

  task automatic test_collision();
    mw = 1'b1;
    din = 64'hDDDD_CCCC_BBBB_AAAA;
    for (int n = 0; n < 4; n++) a[n] = 16'h0020;
    step();
    mw = 1'b0;
    mr = 4'b0001;
    step();
    total++;
    if (dout[0] !== 16'hDDDD) begin
      bad++;
      $display("FAIL collision_dout1 got=%h exp=DDDD", dout[0]);
    end
    mr = 4'h0;
  endtask

  task automatic test_hold_selective();
    logic [15:0] exp [4];
    exp = '{16'h1111, 16'h2222, 16'h1111, 16'h4444};
    for (int n = 0; n < 4; n++) a[n] = 16'h0010;
    mr = 4'b0101;
    step();
    for (int n = 0; n < 4; n++) begin
      total++;
      if (dout[n] !== exp[n]) begin
        bad++;
        $display("FAIL hold_sel_dout%0d got=%h exp=%h", n + 1, dout[n], exp[n]);
      end
    end
    mr = 4'h0;
  endtask

  task automatic test_read_first();
    for (int n = 0; n < 4; n++) a[n] = 16'h0030 + 16'(n);
    mw = 1'b1;
    din = {48'h0, 16'h0BAD};
    step();
    din = {48'h0, 16'h600D};
    mr = 4'b0001;
    step();
    total++;
    if (dout[0] !== 16'h0BAD) begin
      bad++;
      $display("FAIL read_first_same_edge got=%h exp=0BAD", dout[0]);
    end
    mw = 1'b0;
    step();
    total++;
    if (dout[0] !== 16'h600D) begin
      bad++;
      $display("FAIL read_first_next_edge got=%h exp=600D", dout[0]);
    end
    mr = 4'h0;
  endtask

  task automatic test_wrap();
    a[0] = 16'h0040;
    a[1] = 16'h0105;
    a[2] = 16'h0041;
    a[3] = 16'h0042;
    din = {16'h0, 16'h0, 16'h5A5A, 16'h0};
    mw = 1'b1;
    step();
    mw = 1'b0;
    a[2] = 16'h0005;
    mr = 4'b0100;
    step();
    total++;
    if (dout[2] !== 16'h5A5A) begin
      bad++;
      $display("FAIL wrap_dout3 got=%h exp=5A5A", dout[2]);
    end
    mr = 4'h0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      mw = 1'($urandom);
      mr = 4'($urandom);
      din = {$urandom, $urandom};
      for (int n = 0; n < 4; n++) begin
        if ($urandom_range(0, 3) == 0) a[n] = 16'($urandom);
        else a[n] = {8'($urandom), 8'h60 + 8'($urandom_range(0, 3))};
      end
      step();
      for (int n = 0; n < 4; n++) begin
        total++;
        if (dout[n] !== ref_dout[n]) begin
          bad++;
          $display("FAIL random_it%0d_dout%0d got=%h exp=%h", i, n + 1, dout[n], ref_dout[n]);
        end
      end
    end
    mw = 1'b0;
    mr = 4'h0;
  endtask

  task automatic test_reset_midcycle();
    for (int n = 0; n < 4; n++) a[n] = 16'h0010 + 16'(n);
    mr = 4'hF;
    step();
    for (int n = 0; n < 4; n++) begin
      total++;
      if (dout[n] !== ref_dout[n]) begin
        bad++;
        $display("FAIL pre_reset_dout%0d got=%h exp=%h", n + 1, dout[n], ref_dout[n]);
      end
    end
    #3;
    mr = 4'h0;
    mw = 1'b1;
    din = {$urandom, $urandom};
    for (int n = 0; n < 4; n++) a[n] = 16'h0005 + 16'(n);
    rst_n = 1'b0;
    #1;
    for (int n = 0; n < 4; n++) begin
      ref_dout[n] = '0;
      total++;
      if (dout[n] !== 16'h0000) begin
        bad++;
        $display("FAIL async_reset_dout%0d got=%h exp=0000", n + 1, dout[n]);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (dout[0] !== 16'h0000) begin
      bad++;
      $display("FAIL reset_held_dout1 got=%h exp=0000", dout[0]);
    end
    rst_n = 1'b1;
    mw = 1'b0;
`ifdef DM_RESET_CLEAR_EN
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
`endif
    mr = 4'hF;
    step();
    for (int n = 0; n < 4; n++) begin
      total++;
      if (dout[n] !== ref_dout[n]) begin
        bad++;
        $display("FAIL post_reset_read%0d got=%h exp=%h", n + 1, dout[n], ref_dout[n]);
      end
    end
    mr = 4'h0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_parallel();
    test_collision();
    test_hold_selective();
    test_read_first();
    test_wrap();
    test_random();
    test_reset_midcycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
